// File: rtl/distance_conditioner.sv
// distance_conditioner
//   Conditions raw range samples into a smoothed distance for the FM DAC.
//   Each accepted sample is clamped to MAX_DIST and then averaged over the
//   last DEPTH = 2**LOG2_DEPTH accepted samples. The average is a running
//   sum over a circular history buffer. While the buffer is still filling,
//   the unwritten entries count as zero, so the output ramps up from zero.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   clock enable; when low, state holds and samples drop
//   clear          in   synchronous flush of history (only when enable=1)
//   sample_valid   in   one-cycle strobe qualifying sample
//   sample         in   raw unsigned distance sample, WIDTH bits
//   distance       out  conditioned distance, WIDTH bits, 1 clock after accept
//   distance_valid out  one-cycle pulse per new distance value
//   filled         out  high once DEPTH samples accepted since reset/clear
//   over_range     out  sample behind current distance exceeded MAX_DIST
module distance_conditioner #(
  parameter int WIDTH      = 13,
  parameter int LOG2_DEPTH = 4,
  parameter int MAX_DIST   = 2000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] distance,
  output logic             distance_valid,
  output logic             filled,
  output logic             over_range
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = WIDTH + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [WIDTH-1:0] MAX_D    = WIDTH'(MAX_DIST);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Saturate a raw sample to the legal distance range.
  function automatic logic [WIDTH-1:0] clamp_dist(input logic [WIDTH-1:0] x);
    return (x > MAX_D) ? MAX_D : x;
  endfunction

  // Divide the running sum by DEPTH, truncating toward zero.
  function automatic logic [WIDTH-1:0] scale_avg(input logic [ACC_W-1:0] a);
    return WIDTH'(a >> LOG2_DEPTH);
  endfunction

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       hist [DEPTH];
  logic [ACC_W-1:0]       acc;
  logic [LOG2_DEPTH-1:0]  wr_ptr;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   vld_p1;

  logic                   accept;
  logic                   flush;
  logic [WIDTH-1:0]       s_p0;
  logic [WIDTH-1:0]       old_p0;
  logic                   over_p0;
  logic [ACC_W-1:0]       acc_next_p0;

  // Stage p0: qualify, clamp, and form the updated running sum combinationally.
  // clear wins over a simultaneous sample; both are ignored with enable low.
  assign accept      = enable & sample_valid & ~clear;
  assign flush       = enable & clear;
  assign s_p0        = clamp_dist(sample);
  assign over_p0     = (sample > MAX_D);
  assign old_p0      = hist[wr_ptr];
  // acc already contains old_p0, so adding first and then subtracting cannot
  // underflow, and the peak of DEPTH*MAX_DIST + MAX_DIST fits in ACC_W bits.
  assign acc_next_p0 = acc + ACC_W'(s_p0) - ACC_W'(old_p0);

  // Fill/run state machine: register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill/run state machine: next state. RUN is left only through clear or reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (flush) begin
          state_d = FILL;
        end else if (accept && (fill_cnt == CNT_LAST)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Stage p1: commit history, running sum, pointer, fill count and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
      acc        <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      distance   <= '0;
      over_range <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          hist[i] <= '0;
        end
        acc        <= '0;
        wr_ptr     <= '0;
        fill_cnt   <= '0;
        distance   <= '0;
        over_range <= 1'b0;
      end else if (accept) begin
        hist[wr_ptr] <= s_p0;
        acc          <= acc_next_p0;
        // Natural binary wrap from DEPTH-1 back to 0.
        wr_ptr       <= wr_ptr + LOG2_DEPTH'(1);
        if (fill_cnt != CNT_FULL) begin
          fill_cnt <= fill_cnt + CNT_W'(1);
        end
        distance   <= scale_avg(acc_next_p0);
        over_range <= over_p0;
      end
    end
  end

  assign distance_valid = vld_p1;
  assign filled         = (state_q == RUN);

endmodule
